// File: rtl/bpsk_tx_framer.sv
// BPSK transmit framer: alternating preamble, 16-bit sync word, then N payload bytes MSB first,
// one bit per SYM_DIV clocks, with a one-byte holding buffer fed over valid/ready.
module bpsk_tx_framer #(
   parameter int          SYM_DIV   = 2000,
   parameter int          PRE_LEN   = 16,
   parameter logic [15:0] SYNC_WORD = 16'hF3A0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] frame_len,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       tx_bit,
   output logic       sym_tick,
   output logic       busy,
   output logic       done,
   output logic       underrun,
   output logic [1:0] dbg_state
);
   localparam int CNT_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_SYNC, S_PAYLOAD} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       buf_q, buf_d;
   logic             buf_full_q, buf_full_d;
   logic [7:0]       len_q, len_d;
   logic [7:0]       fetched_q, fetched_d;
   logic [7:0]       loaded_q, loaded_d;
   logic             tx_bit_q, tx_bit_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             underrun_q, underrun_d;
   logic             tick, xfer, need_load, finish;

   // Handshake: a byte moves when byte_valid && byte_ready at a rising clk edge; byte_ready
   // depends only on registered state, byte_data must be stable while byte_valid is high.
   assign tick       = busy_q && (cnt_q == CNT_W'(SYM_DIV - 1));
   assign byte_ready = busy_q && !buf_full_q && (fetched_q < len_q);
   assign xfer       = byte_valid && byte_ready;

   assign sym_tick  = tick;
   assign tx_bit    = tx_bit_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign underrun  = underrun_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shreg_d    = shreg_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      len_d      = len_q;
      fetched_d  = fetched_q;
      loaded_d   = loaded_q;
      tx_bit_d   = tx_bit_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      need_load  = 1'b0;
      finish     = 1'b0;

      if (xfer) begin
         buf_d      = byte_data;
         buf_full_d = 1'b1;
         fetched_d  = fetched_q + 8'd1;
      end
      if (busy_q) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

      case (state_q)
         S_IDLE: begin
            cnt_d    = '0;
            tx_bit_d = 1'b0;
            busy_d   = 1'b0;
            if (start && (frame_len != 8'd0)) begin
               state_d    = S_PREAMBLE;
               len_d      = frame_len;
               busy_d     = 1'b1;
               tx_bit_d   = 1'b1;
               bit_idx_d  = '0;
               fetched_d  = '0;
               loaded_d   = '0;
               buf_full_d = 1'b0;
            end
         end
         S_PREAMBLE: if (tick) begin
            if (bit_idx_q == 5'(PRE_LEN - 1)) begin
               state_d   = S_SYNC;
               bit_idx_d = 5'd15;
               tx_bit_d  = SYNC_WORD[15];
            end else begin
               // Next index is bit_idx+1; even indices carry 1, so the next bit is bit_idx[0].
               bit_idx_d = bit_idx_q + 5'd1;
               tx_bit_d  = bit_idx_q[0];
            end
         end
         S_SYNC: if (tick) begin
            if (bit_idx_q == 5'd0) begin
               need_load = 1'b1;
            end else begin
               bit_idx_d = bit_idx_q - 5'd1;
               tx_bit_d  = SYNC_WORD[bit_idx_d[3:0]];
            end
         end
         S_PAYLOAD: if (tick) begin
            if (bit_idx_q == 5'd0) begin
               if (loaded_q == len_q) finish = 1'b1;
               else                   need_load = 1'b1;
            end else begin
               bit_idx_d = bit_idx_q - 5'd1;
               tx_bit_d  = shreg_q[bit_idx_d[2:0]];
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A load can never coincide with a buffer fill, since byte_ready requires an empty buffer.
      if (need_load && buf_full_q) begin
         state_d    = S_PAYLOAD;
         shreg_d    = buf_q;
         buf_full_d = 1'b0;
         loaded_d   = loaded_q + 8'd1;
         bit_idx_d  = 5'd7;
         tx_bit_d   = buf_q[7];
      end
      if ((need_load && !buf_full_q) || finish) begin
         state_d    = S_IDLE;
         busy_d     = 1'b0;
         tx_bit_d   = 1'b0;
         cnt_d      = '0;
         done_d     = finish;
         underrun_d = need_load;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shreg_q    <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         len_q      <= '0;
         fetched_q  <= '0;
         loaded_q   <= '0;
         tx_bit_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shreg_q    <= shreg_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         len_q      <= len_d;
         fetched_q  <= fetched_d;
         loaded_q   <= loaded_d;
         tx_bit_q   <= tx_bit_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end
endmodule

// File: tb/tb_bpsk_tx_framer.sv
// Directed bench for bpsk_tx_framer with SYM_DIV=4, PRE_LEN=4: whole frames are captured
// bit-per-tick and compared with hand-built preamble/sync/payload patterns.
module tb_bpsk_tx_framer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] frame_len = 8'd0;
   logic [7:0] byte_data = 8'd0;
   logic       byte_valid = 1'b0;
   logic       byte_ready, tx_bit, sym_tick, busy, done, underrun;
   logic [1:0] dbg_state;

   int         tests_run = 0;
   int         fails = 0;
   logic [7:0] pay [0:3];

   logic [63:0] bits;
   int          nbits, busy_cyc, xfers;
   bit          ready_late, tick_err, side_pulse, end_done, end_under, end_tx;
   bit          any_bad;

   bpsk_tx_framer #(.SYM_DIV(4), .PRE_LEN(4), .SYNC_WORD(16'hF3A0)) dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .tx_bit(tx_bit), .sym_tick(sym_tick), .busy(busy), .done(done),
      .underrun(underrun), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called in the first busy cycle; runs until busy drops, returning at the first idle cycle.
   task automatic watch_frame(input int len, input int valid_delay, input int nsupply,
                              input int pulse_cyc);
      int c = 0;
      int last_tick = -1;
      int idx = 0;
      bit prev_tx = 1'b0;
      bit prev_tick = 1'b0;
      bits = '0; nbits = 0; busy_cyc = 0; xfers = 0;
      ready_late = 0; tick_err = 0; side_pulse = 0;
      while (busy && c < 2000) begin
         if (pulse_cyc >= 0) begin
            start     = (c == pulse_cyc);
            frame_len = (c == pulse_cyc) ? 8'd5 : 8'd1;
         end
         byte_valid = (c >= valid_delay) && (idx < nsupply);
         byte_data  = byte_valid ? pay[idx] : 8'h00;
         if (byte_ready && xfers >= len) ready_late = 1;
         if (byte_valid && byte_ready) begin
            xfers++;
            idx++;
         end
         busy_cyc++;
         if (c > 0 && tx_bit != prev_tx && !prev_tick) tick_err = 1;
         if (sym_tick) begin
            if (c - last_tick != 4) tick_err = 1;
            last_tick = c;
            bits = {bits[62:0], tx_bit};
            nbits++;
         end
         if (done || underrun) side_pulse = 1;
         prev_tx   = tx_bit;
         prev_tick = sym_tick;
         step();
         c++;
      end
      check("frame_timeout", {63'd0, busy}, 64'd0);
      if (!prev_tick) tick_err = 1;
      end_done   = done;
      end_under  = underrun;
      end_tx     = tx_bit;
      byte_valid = 1'b0;
   endtask

   task automatic start_frame(input logic [7:0] len);
      frame_len = len;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      check("reset_outputs", {58'd0, busy, tx_bit, done, underrun, byte_ready, sym_tick}, 64'd0);
      check("reset_state", {62'd0, dbg_state}, 64'd0);
      step();

      // Single-byte frame, data valid immediately
      pay[0] = 8'hA5;
      byte_valid = 1'b1; byte_data = 8'hA5;
      start_frame(8'd1);
      check("first_cycle_tx", {63'd0, tx_bit}, 64'd1);
      watch_frame(1, 0, 1, -1);
      check("single_bits", bits, 64'h000000000AF3A0A5);
      check("single_nbits", nbits, 28);
      check("single_busy_cycles", busy_cyc, 112);
      check("single_tick_timing", {63'd0, tick_err}, 64'd0);
      check("single_done", {61'd0, end_done, end_under, end_tx}, 64'b100);
      check("single_no_early_pulse", {63'd0, side_pulse}, 64'd0);
      step();
      check("single_done_once", {62'd0, done, busy}, 64'd0);

      // Late byte: valid only from 10 cycles after start
      pay[0] = 8'h3C;
      start_frame(8'd1);
      watch_frame(1, 10, 1, -1);
      check("hs_bits", bits, 64'h000000000AF3A03C);
      check("hs_xfers", xfers, 1);
      check("hs_ready_after_fetch", {63'd0, ready_late}, 64'd0);
      check("hs_done", {61'd0, end_done, end_under, end_tx}, 64'b100);
      step();

      // Underrun: two bytes requested, one supplied
      pay[0] = 8'h5A;
      start_frame(8'd2);
      watch_frame(2, 0, 1, -1);
      check("ur_bits", bits, 64'h000000000AF3A05A);
      check("ur_busy_cycles", busy_cyc, 112);
      check("ur_flags", {61'd0, end_done, end_under, end_tx}, 64'b010);
      check("ur_no_early_pulse", {63'd0, side_pulse}, 64'd0);
      step();
      check("ur_pulse_once", {61'd0, underrun, busy, done}, 64'd0);
      step();

      // Back-to-back: start held high across the done cycle
      pay[0] = 8'h81;
      frame_len = 8'd1;
      start = 1'b1;
      step();
      watch_frame(1, 0, 1, -1);
      check("b2b_f1_bits", bits, 64'h000000000AF3A081);
      check("b2b_f1_done", {63'd0, end_done}, 64'd1);
      pay[0] = 8'h7E;
      step();
      check("b2b_no_gap", {62'd0, busy, tx_bit}, 64'b11);
      start = 1'b0;
      watch_frame(1, 0, 1, -1);
      check("b2b_f2_bits", bits, 64'h000000000AF3A07E);
      check("b2b_f2_busy_cycles", busy_cyc, 112);
      check("b2b_f2_tick_timing", {63'd0, tick_err}, 64'd0);
      check("b2b_f2_done", {63'd0, end_done}, 64'd1);
      step();

      // Reset in the middle of SYNC
      byte_valid = 1'b1; byte_data = 8'h11;
      start_frame(8'd1);
      for (int i = 0; i < 40; i++) step();
      check("mid_state_sync", {62'd0, dbg_state}, 64'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      byte_valid = 1'b0;
      check("mid_rst_outputs", {58'd0, busy, tx_bit, done, underrun, byte_ready, sym_tick}, 64'd0);
      any_bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (busy || done || underrun || tx_bit) any_bad = 1;
      end
      check("mid_rst_quiet", {63'd0, any_bad}, 64'd0);
      pay[0] = 8'h96;
      start_frame(8'd1);
      watch_frame(1, 0, 1, -1);
      check("post_rst_bits", bits, 64'h000000000AF3A096);
      check("post_rst_done", {61'd0, end_done, end_under, end_tx}, 64'b100);
      step();

      // frame_len=0 request is ignored
      start_frame(8'd0);
      any_bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (busy || byte_ready) any_bad = 1;
         step();
      end
      check("len0_ignored", {63'd0, any_bad}, 64'd0);

      // start pulse during PAYLOAD has no effect
      pay[0] = 8'hC3;
      start_frame(8'd1);
      watch_frame(1, 0, 1, 90);
      start = 1'b0;
      check("busy_start_bits", bits, 64'h000000000AF3A0C3);
      check("busy_start_cycles", busy_cyc, 112);
      check("busy_start_done", {63'd0, end_done}, 64'd1);
      step();
      check("busy_start_stays_idle", {63'd0, busy}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
